// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the 32-bit to 8-bit Wishbone byte bridge: FSM encoding,
// lane-to-offset mapping and helpers for moving bytes between word and byte bus.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BYTE = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Big-endian: the most significant select bit maps to the lowest byte address.
    localparam logic [1:0] LANE3_OFFSET = 2'd0;
    localparam logic [1:0] LANE2_OFFSET = 2'd1;
    localparam logic [1:0] LANE1_OFFSET = 2'd2;
    localparam logic [1:0] LANE0_OFFSET = 2'd3;

    localparam int TIMEOUT_WIDTH_DEFAULT = 8;

    // Reorders a Wishbone select vector so that bit N means "byte offset N is wanted".
    function automatic logic [3:0] sel_to_offset_mask(input logic [3:0] sel);
        logic [3:0] m;
        m = 4'h0;
        m[LANE3_OFFSET] = sel[3];
        m[LANE2_OFFSET] = sel[2];
        m[LANE1_OFFSET] = sel[1];
        m[LANE0_OFFSET] = sel[0];
        return m;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] offset);
        logic [7:0] b;
        case (offset)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [1:0] offset,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (offset)
            2'd0:    w[31:24] = b;
            2'd1:    w[23:16] = b;
            2'd2:    w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/wb_byte_lane_sel.sv
// Picks the lowest pending byte offset from a lane mask, returns the mask with
// that lane removed, and flags whether it is the final lane.
module wb_byte_lane_sel (
    input  logic [3:0] lane_mask,
    output logic [1:0] next_offset,
    output logic [3:0] next_mask,
    output logic       last_lane
);

    always_comb begin
        next_offset = 2'd0;
        if (lane_mask[0]) begin
            next_offset = 2'd0;
        end else if (lane_mask[1]) begin
            next_offset = 2'd1;
        end else if (lane_mask[2]) begin
            next_offset = 2'd2;
        end else if (lane_mask[3]) begin
            next_offset = 2'd3;
        end
        next_mask              = lane_mask;
        next_mask[next_offset] = 1'b0;
        last_lane              = (next_mask == 4'h0);
    end

endmodule

// File: rtl/wb_byte_bridge.sv
// Splits one 32-bit Wishbone access into byte accesses on an 8-bit bus.
// Define WB_BYTE_BRIDGE_TIMEOUT_EN to build a watchdog that errors stalled byte accesses.
module wb_byte_bridge
    import wb_bridge_pkg::*;
#(
    parameter int wb_adr_width  = 32,
    parameter int timeout_width = TIMEOUT_WIDTH_DEFAULT
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    input  logic [wb_adr_width-1:0] wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic                    wbs_we_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    output logic [31:0]             wbs_dat_o,
    output logic                    wbs_ack_o,
    output logic                    wbs_err_o,
    output logic                    wbs_rty_o,
    output logic [wb_adr_width-1:0] wbm_adr_o,
    output logic [7:0]              wbm_dat_o,
    output logic                    wbm_we_o,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    input  logic [7:0]              wbm_dat_i,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    input  logic                    wbm_rty_i,
    output state_t                  dbg_state
);

    // Handshake: upstream request is cyc&stb held until ack/err; downstream
    // each cycle with stb high and ack/err/rty high completes one byte.
    state_t                  state;
    logic [wb_adr_width-3:0] adr_q;
    logic [31:0]             dat_q;
    logic [31:0]             rbuf;
    logic [3:0]              rem_mask;
    logic                    on_last;
    logic                    ack_q;
    logic                    err_q;
    logic                    req;
    logic                    wdog_expired;

    logic [3:0] enc_mask;
    logic [1:0] enc_offset;
    logic [3:0] enc_next_mask;
    logic       enc_last;

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign enc_mask = (state == ST_IDLE) ? sel_to_offset_mask(wbs_sel_i) : rem_mask;

    wb_byte_lane_sel u_lane_sel (
        .lane_mask   (enc_mask),
        .next_offset (enc_offset),
        .next_mask   (enc_next_mask),
        .last_lane   (enc_last)
    );

`ifdef WB_BYTE_BRIDGE_TIMEOUT_EN
    logic [timeout_width-1:0] wdog_cnt;

    // Restarts for every byte strobe: any ack moves on to a fresh lane.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wdog_cnt <= '0;
        end else if (state != ST_BYTE || wbm_ack_i) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign wdog_expired = &wdog_cnt;
`else
    logic [timeout_width-1:0] unused_timeout_width;
    assign unused_timeout_width = '0;
    assign wdog_expired         = 1'b0;
`endif

    logic [1:0] unused_adr_bits;
    assign unused_adr_bits = wbs_adr_i[1:0];

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= ST_IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            rbuf      <= '0;
            rem_mask  <= '0;
            on_last   <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (req) begin
                        adr_q <= wbs_adr_i[wb_adr_width-1:2];
                        dat_q <= wbs_dat_i;
                        rbuf  <= '0;
                        if (wbs_sel_i != 4'h0) begin
                            state     <= ST_BYTE;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= wbs_we_i;
                            wbm_adr_o <= {wbs_adr_i[wb_adr_width-1:2], enc_offset};
                            wbm_dat_o <= lane_byte(wbs_dat_i, enc_offset);
                            rem_mask  <= enc_next_mask;
                            on_last   <= enc_last;
                        end else begin
                            state <= ST_RESP;
                            ack_q <= 1'b1;
                        end
                    end
                end

                ST_BYTE: begin
                    if (!wbs_cyc_i) begin
                        // Master abandoned the cycle: quietly drop the byte bus.
                        state     <= ST_IDLE;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                    end else if (wbm_err_i || wbm_rty_i || (wdog_expired && !wbm_ack_i)) begin
                        state     <= ST_RESP;
                        err_q     <= 1'b1;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                    end else if (wbm_ack_i) begin
                        if (!wbm_we_o) begin
                            rbuf <= put_lane(rbuf, wbm_adr_o[1:0], wbm_dat_i);
                        end
                        if (on_last) begin
                            state     <= ST_RESP;
                            ack_q     <= 1'b1;
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            wbm_we_o  <= 1'b0;
                        end else begin
                            wbm_adr_o <= {adr_q, enc_offset};
                            wbm_dat_o <= lane_byte(dat_q, enc_offset);
                            rem_mask  <= enc_next_mask;
                            on_last   <= enc_last;
                        end
                    end
                end

                ST_RESP: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Responses are masked by the live request so they never appear outside a cycle.
    assign wbs_ack_o = ack_q & req;
    assign wbs_err_o = err_q & req;
    assign wbs_dat_o = wbs_ack_o ? rbuf : 32'h0;
    assign wbs_rty_o = 1'b0;
    assign dbg_state = state;

endmodule

// File: doc/wb_byte_bridge.md
WB_BYTE_BRIDGE -- requirements
Module: wb_byte_bridge

Interface
REQ-001 Parameter wb_adr_width, default 32: address width on both sides.
REQ-002 Parameter timeout_width, default 8: width of the byte-access watchdog counter.
REQ-003 Port wb_clk, input, 1: single clock; all logic is on the rising edge.
REQ-004 Port wb_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Ports wbs_adr_i (wb_adr_width), wbs_dat_i (32), wbs_sel_i (4), wbs_we_i, wbs_cyc_i, wbs_stb_i (1 each), inputs: 32-bit Wishbone slave request from the data-bus arbiter default slot.
REQ-006 Ports wbs_dat_o (32), wbs_ack_o, wbs_err_o, wbs_rty_o (1 each), outputs: 32-bit slave response.
REQ-007 Ports wbm_adr_o (wb_adr_width), wbm_dat_o (8), wbm_we_o, wbm_cyc_o, wbm_stb_o (1 each), outputs: 8-bit byte-bus master request.
REQ-008 Ports wbm_dat_i (8), wbm_ack_i, wbm_err_i, wbm_rty_i (1 each), inputs: byte-bus response.

Function
REQ-009 States: IDLE, BYTE, RESP; 2-bit encoding from the package.
REQ-010 IDLE + wbs_cyc_i & wbs_stb_i: latch adr[wb_adr_width-1:2], dat, sel, we; clear read buffer; go to BYTE if sel!=0, else RESP.
REQ-011 Lane order is big-endian ascending offset: sel[3]->offset 0 with dat[31:24]; sel[2]->offset 1 with [23:16]; sel[1]->offset 2 with [15:8]; sel[0]->offset 3 with [7:0]; unselected lanes are skipped.
REQ-012 In BYTE, wbm_cyc_o=wbm_stb_o=1, wbm_adr_o={latched adr[wb_adr_width-1:2], offset}, wbm_dat_o=latched lane byte, wbm_we_o=latched we; all registered.
REQ-013 On wbm_ack_i in BYTE: if read, store wbm_dat_i into the current lane; advance to the next selected lane with no idle cycle; after the last lane, deassert cyc/stb and go to RESP.
REQ-014 In RESP, wbs_ack_o=1 for exactly one cycle with wbs_dat_o=assembled buffer; unselected lanes and all write-cycle data read 0; then return to IDLE.
REQ-015 wbm_err_i or wbm_rty_i in BYTE: abort remaining lanes; one-cycle wbs_err_o in RESP, with no wbs_ack_o.
REQ-016 wbs_rty_o is constant 0.
REQ-017 If wbs_cyc_i drops while in BYTE: wbm_cyc_o/stb_o go low the next cycle; state returns to IDLE; no upstream ack/err is issued.
REQ-018 wbs_ack_o and wbs_err_o are never both 1, and only assert while wbs_cyc_i & wbs_stb_i.
REQ-019 Latency for N selected lanes with single-cycle byte acks is N+2 cycles from request to wbs_ack_o; with sel=0 it is 2 cycles.

Reset
REQ-020 While wb_rst_n=0, state=IDLE and all outputs, the buffer and the counter are 0, asynchronously; release is synchronous to wb_clk.
REQ-021 Reset mid-transfer drops wbm_cyc_o immediately; no response is issued.

Configuration
REQ-022 With WB_BYTE_BRIDGE_TIMEOUT_EN defined, the counter clears on each byte strobe start and increments each BYTE cycle without ack; at all-ones it aborts as in REQ-015 with wbs_err_o.
REQ-023 Without WB_BYTE_BRIDGE_TIMEOUT_EN, no counter is built and BYTE waits indefinitely.

Structure
REQ-024 Package wb_bridge_pkg holds the state encoding, the lane-to-offset constants and the TIMEOUT default.
REQ-025 Sub-module wb_byte_lane_sel is a combinational priority encoder: remaining-lane mask -> next offset plus last-lane flag.

Verification
REQ-026 Read with sel=4'hF at adr 0x9100_0000, byte slave returns 11,22,33,44: four byte strobes at 0x..00..03, then wbs_dat_o=0x11223344 and one wbs_ack_o at cycle 6.
REQ-027 Write with sel=4'b0100, dat=0xAABBCCDD: single byte write at offset 1 with data 0xBB, then wbs_ack_o.
REQ-028 Read with sel=4'b1001, slave wbm_err_i on the first lane: no second strobe; wbs_err_o pulses once; wbs_ack_o stays 0.
REQ-029 Read with sel=4'hF, wbs_cyc_i dropped after lane 1 ack: wbm_cyc_o low the next cycle, FSM in IDLE, no ack; the following request completes normally.
REQ-030 WB_BYTE_BRIDGE_TIMEOUT_EN with a byte slave that never acks: wbs_err_o asserts 256 cycles after strobe; without the macro, the bridge is still in BYTE after 1000 cycles.
REQ-031 wb_rst_n pulsed low mid-BYTE: all outputs 0 within the same cycle, and the state is IDLE after release.
